alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single pipeline ALU between two requesters: port 0, the EX stage, and port 1, the branch/compare resolve unit. It uses valid/ready handshakes and round-robin arbitration. Each operation takes three states in sequence:
- Capture: the granted operands are latched.
- Execute: the latched operands drive the combinational ALU for one cycle.
- Respond: the registered result is returned to the granted requester, with a tag, until that requester accepts it.

## Interface
- DATA_W, 32, operand/result width
- CTRL_W, 6, ALU control code width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Req0Valid / Req1Valid  in  1  request present
- Req0Ready / Req1Ready  out  1  request accepted this cycle (grant)
- Req0Ctrl / Req1Ctrl  in  CTRL_W  ALU control code
- Req0A, Req0B / Req1A, Req1B  in  DATA_W  operands
- Req0Shamt / Req1Shamt  in  5  shift amount
- AluCtrl  out  CTRL_W  to shared ALU
- AluA, AluB  out  DATA_W  to shared ALU
- AluShamt  out  5  to shared ALU
- AluResult  in  DATA_W  from ALU
- AluOverFlow, AluWriteEnable, AluJrSel  in  1  from ALU
- Rsp0Valid / Rsp1Valid  out  1  result available for that requester
- Rsp0Ready / Rsp1Ready  in  1  requester consumes result
- RspResult  out  DATA_W  registered result (shared bus, qualified by RspNValid)
- RspZero, RspOverFlow, RspWriteEnable, RspJrSel  out  1  registered flags

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - If any ReqNValid, assert the granted ReqNReady combinationally.
  - Latch Ctrl/A/B/Shamt and tag = N into the op register, then go to EXEC.
- **Arbitration:**
  - Single valid: grant it.
  - Both valid: grant the port not equal to LastGrant.
  - LastGrant updates on every grant.
- **EXEC:**
  - Alu* outputs are driven from the op register.
  - At the clock edge, capture AluResult, AluOverFlow, AluWriteEnable and AluJrSel into the result register, then go to RESP.
- **RespZero:** computed by this block as (captured result == 0). The ALU's Zero output is not used.
- **RESP:**
  - Rsp[tag]Valid = 1; the other RspValid = 0.
  - Hold all Rsp* outputs stable until Rsp[tag]Ready.
  - On Rsp[tag]Ready with any ReqNValid: accept a new request in the same cycle (arbitrate as in IDLE), then go to EXEC.
  - On Rsp[tag]Ready with no ReqNValid: go to IDLE.
  - Rsp[other]Ready is ignored.
- **ReqNReady outside acceptance:** 0 in EXEC, and 0 in RESP unless Rsp[tag]Ready is high that cycle.
- **Alu* outputs when not in EXEC:** they still reflect the op register, so the ALU input only changes at acceptance.
- **Overflow handling:** RspWriteEnable = 0 on ALU overflow is passed through unchanged. The requester discards the result; this block never retries.
- **Reset, asserted at any time including mid-EXEC or mid-RESP:**
  - State returns to IDLE; the in-flight operation is dropped. The requester reissues after reset.
  - LastGrant = 1, so port 0 wins the first contention.
  - Op and result registers go to 0; tag = 0.
  - All ReqReady and RspValid = 0; RspResult = 0; RspZero = 0.
  - All other flags = 0.

## Timing
- **Latency:** request accepted in cycle t → EXEC in t+1 → Rsp[tag]Valid in t+2.
- **Throughput:**
  - With an immediately-ready consumer: one operation per 2 cycles.
  - Back-to-back acceptances sit in the RESP→EXEC cycle.
- **Handshake rules:**
  - A requester holds Valid and its operands stable until Ready.
  - Ready may depend combinationally on Valid and RspReady; Valid must not depend on Ready.
- **Fairness:** under continuous contention from both ports, grants strictly alternate.
- **Registered outputs:** all Rsp* outputs come from flops. Only ReqNReady is combinational.
- **ALU timing constraint:** the ALU output is sampled only at the end of EXEC, so the ALU's combinational path must settle within one cycle.

## Structure
- Shared package alu_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - ALU control constants: AND=6'd0, OR=6'd1, ADD=6'd2, SUB=6'd6, SLT=6'd7, SLL=6'd8, BEQ=6'd34, JR=6'd32;
  - DATA_W and CTRL_W defaults.
- Sub-module rr_arb2 contains the two-requester round-robin: inputs Valid[1:0] and Enable, outputs Grant[1:0], plus the LastGrant flop.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- **Single ADD:** after reset, Req0 ADD A=5 B=7 → Req0Ready same cycle. Two cycles later: Rsp0Valid, RspResult=12, RspZero=0, Rsp1Valid=0.
- **Contention:** Req0 and Req1 valid continuously, both SUB A=9 B=9. Grants go 0,1,0,1 in order; every response has RspResult=0 and RspZero=1.
- **Backpressure:** Rsp1Ready held low for 5 cycles after Rsp1Valid. RspResult stays stable, no new grant, ReqNReady=0; on Rsp1Ready the pending Req0 is accepted that same cycle.
- **Overflow:** ADD A=32'h7FFFFFFF B=1 → RspResult=32'h80000000, RspOverFlow=1, RspWriteEnable=0.
- **Reset mid-EXEC:** assert Reset during EXEC of Req1 SLT → Rsp1Valid never rises and all outputs read 0. After release, the first contended grant goes to port 0.
- **JR pass-through:** Req1 JR A=32'h00400020 → RspJrSel=1, RspWriteEnable=0, RspResult=32'h00400020.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: widths, FSM states and ALU
// control codes.
package alu_pkg;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [CTRL_W-1:0] ALU_AND = 6'd0;
   localparam logic [CTRL_W-1:0] ALU_OR  = 6'd1;
   localparam logic [CTRL_W-1:0] ALU_ADD = 6'd2;
   localparam logic [CTRL_W-1:0] ALU_SUB = 6'd6;
   localparam logic [CTRL_W-1:0] ALU_SLT = 6'd7;
   localparam logic [CTRL_W-1:0] ALU_SLL = 6'd8;
   localparam logic [CTRL_W-1:0] ALU_JR  = 6'd32;
   localparam logic [CTRL_W-1:0] ALU_BEQ = 6'd34;

   function automatic logic [1:0] port_onehot(input logic tag);
      return tag ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, response and shared-ALU signals of the arbiter. Index 0 of each
// pair is the EX stage, index 1 the branch/compare resolve unit.
interface alu_share_arbiter_if #(
   parameter int DW = alu_pkg::DATA_W,
   parameter int CW = alu_pkg::CTRL_W
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0][CW-1:0]  req_ctrl;
   logic [1:0][DW-1:0]  req_a;
   logic [1:0][DW-1:0]  req_b;
   logic [1:0][4:0]     req_shamt;

   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready;
   logic [DW-1:0]       rsp_result;
   logic                rsp_zero;
   logic                rsp_overflow;
   logic                rsp_write_enable;
   logic                rsp_jr_sel;

   logic [CW-1:0]       alu_ctrl;
   logic [DW-1:0]       alu_a;
   logic [DW-1:0]       alu_b;
   logic [4:0]          alu_shamt;
   logic [DW-1:0]       alu_result;
   logic                alu_overflow;
   logic                alu_write_enable;
   logic                alu_jr_sel;

   modport slave (
      input  req_valid, req_ctrl, req_a, req_b, req_shamt, rsp_ready,
      input  alu_result, alu_overflow, alu_write_enable, alu_jr_sel,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
      output rsp_write_enable, rsp_jr_sel,
      output alu_ctrl, alu_a, alu_b, alu_shamt
   );

   modport master (
      output req_valid, req_ctrl, req_a, req_b, req_shamt, rsp_ready,
      output alu_result, alu_overflow, alu_write_enable, alu_jr_sel,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
      input  rsp_write_enable, rsp_jr_sel,
      input  alu_ctrl, alu_a, alu_b, alu_shamt
   );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-requester round-robin: on contention the port that did not win last time
// is granted. Grants are only issued while enable_i is high.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       enable_i,
   output logic [1:0] grant_o
);
   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant_o      = 2'b00;
      last_grant_d = last_grant_q;
      if (enable_i) begin
         unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
      if (grant_o != 2'b00) begin
         last_grant_d = grant_o[1];
      end
   end

   // Reset value 1 lets port 0 win the first contention.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: capture operands,
// drive the ALU for one cycle, then hold the registered result until accepted.
module alu_share_arbiter
   import alu_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   alu_share_arbiter_if.slave bus_io
);
   state_t              state_q, state_d;
   logic [CTRL_W-1:0]   op_ctrl_q, op_ctrl_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d;
   logic [DATA_W-1:0]   op_b_q, op_b_d;
   logic [4:0]          op_shamt_q, op_shamt_d;
   logic                op_tag_q, op_tag_d;

   logic [DATA_W-1:0]   res_q, res_d;
   logic                res_zero_q, res_zero_d;
   logic                res_ovf_q, res_ovf_d;
   logic                res_we_q, res_we_d;
   logic                res_jr_q, res_jr_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;

   logic                accept_en;
   logic [1:0]          grant;

   // A new request may be taken when idle, or when the pending result is
   // consumed in the same cycle; never while reset is held.
   assign accept_en = !rst_i &&
                      ((state_q == IDLE) ||
                       (state_q == RESP && bus_io.rsp_ready[op_tag_q]));

   rr_arb2 u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (bus_io.req_valid),
      .enable_i (accept_en),
      .grant_o  (grant)
   );

   always_comb begin
      state_d     = state_q;
      op_ctrl_d   = op_ctrl_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_shamt_d  = op_shamt_q;
      op_tag_d    = op_tag_q;
      res_d       = res_q;
      res_zero_d  = res_zero_q;
      res_ovf_d   = res_ovf_q;
      res_we_d    = res_we_q;
      res_jr_d    = res_jr_q;
      rsp_valid_d = rsp_valid_q;

      unique case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_d       = bus_io.alu_result;
            res_zero_d  = (bus_io.alu_result == '0);
            res_ovf_d   = bus_io.alu_overflow;
            res_we_d    = bus_io.alu_write_enable;
            res_jr_d    = bus_io.alu_jr_sel;
            rsp_valid_d = port_onehot(op_tag_q);
            state_d     = RESP;
         end
         RESP: begin
            if (bus_io.rsp_ready[op_tag_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = (grant != 2'b00) ? EXEC : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant != 2'b00) begin
         op_ctrl_d  = bus_io.req_ctrl[grant[1]];
         op_a_d     = bus_io.req_a[grant[1]];
         op_b_d     = bus_io.req_b[grant[1]];
         op_shamt_d = bus_io.req_shamt[grant[1]];
         op_tag_d   = grant[1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         op_ctrl_q   <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_shamt_q  <= '0;
         op_tag_q    <= 1'b0;
         res_q       <= '0;
         res_zero_q  <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_we_q    <= 1'b0;
         res_jr_q    <= 1'b0;
         rsp_valid_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         op_ctrl_q   <= op_ctrl_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_shamt_q  <= op_shamt_d;
         op_tag_q    <= op_tag_d;
         res_q       <= res_d;
         res_zero_q  <= res_zero_d;
         res_ovf_q   <= res_ovf_d;
         res_we_q    <= res_we_d;
         res_jr_q    <= res_jr_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // The ALU sees the op register at all times, so its inputs only move on acceptance.
   assign bus_io.alu_ctrl         = op_ctrl_q;
   assign bus_io.alu_a            = op_a_q;
   assign bus_io.alu_b            = op_b_q;
   assign bus_io.alu_shamt        = op_shamt_q;

   assign bus_io.req_ready        = grant;
   assign bus_io.rsp_valid        = rsp_valid_q;
   assign bus_io.rsp_result       = res_q;
   assign bus_io.rsp_zero         = res_zero_q;
   assign bus_io.rsp_overflow     = res_ovf_q;
   assign bus_io.rsp_write_enable = res_we_q;
   assign bus_io.rsp_jr_sel       = res_jr_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single operations plus
// sequences for contention, backpressure and asynchronous reset mid-operation.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_share_arbiter_if bus ();

   alu_share_arbiter dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   // Stand-in for the shared ALU that the parent would normally instantiate.
   logic [31:0] m_res;
   logic [31:0] m_tmp;
   logic        m_ovf;
   logic        m_we;
   logic        m_jr;
   always_comb begin
      m_res = 32'd0;
      m_tmp = 32'd0;
      m_ovf = 1'b0;
      m_we  = 1'b1;
      m_jr  = 1'b0;
      case (bus.alu_ctrl)
         ALU_AND: m_res = bus.alu_a & bus.alu_b;
         ALU_OR:  m_res = bus.alu_a | bus.alu_b;
         ALU_ADD: begin
            m_tmp = bus.alu_a + bus.alu_b;
            m_res = m_tmp;
            m_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (m_tmp[31] != bus.alu_a[31]);
         end
         ALU_SUB: begin
            m_tmp = bus.alu_a - bus.alu_b;
            m_res = m_tmp;
            m_ovf = (bus.alu_a[31] != bus.alu_b[31]) && (m_tmp[31] != bus.alu_a[31]);
         end
         ALU_SLT: m_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
         ALU_SLL: m_res = bus.alu_b << bus.alu_shamt;
         ALU_BEQ: begin
            m_res = bus.alu_a - bus.alu_b;
            m_we  = 1'b0;
         end
         ALU_JR: begin
            m_res = bus.alu_a;
            m_jr  = 1'b1;
            m_we  = 1'b0;
         end
         default: m_res = 32'd0;
      endcase
      if (m_ovf) m_we = 1'b0;
   end
   assign bus.alu_result       = m_res;
   assign bus.alu_overflow     = m_ovf;
   assign bus.alu_write_enable = m_we;
   assign bus.alu_jr_sel       = m_jr;

   typedef struct {
      int          port;
      logic [5:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic        exp_ovf;
      logic        exp_we;
      logic        exp_jr;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int p);
      return (p == 1) ? 32'd2 : 32'd1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int p, input logic [5:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
      bus.req_valid[p] = 1'b1;
      bus.req_ctrl[p]  = c;
      bus.req_a[p]     = a;
      bus.req_b[p]     = b;
      bus.req_shamt[p] = sh;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
      check({tag, "_rsp_flags"}, {28'd0, bus.rsp_zero, bus.rsp_overflow,
                                  bus.rsp_write_enable, bus.rsp_jr_sel}, 32'd0);
      check({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
      check({tag, "_alu_a"}, bus.alu_a, 32'd0);
      check({tag, "_alu_b"}, bus.alu_b, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_p;
      int nxt_p;

      vecs[0] = '{0, ALU_ADD, 32'd5,          32'd7,          5'd0, 32'd12,         1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{0, ALU_ADD, 32'h7FFFFFFF,   32'd1,          5'd0, 32'h80000000,   1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1, ALU_JR,  32'h00400020,   32'd0,          5'd0, 32'h00400020,   1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{1, ALU_AND, 32'hF0F000FF,   32'h0FF00F0F,   5'd0, 32'h00F0000F,   1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{0, ALU_OR,  32'h00001200,   32'h00000034,   5'd0, 32'h00001234,   1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1, ALU_SUB, 32'd5,          32'd7,          5'd0, 32'hFFFFFFFE,   1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{0, ALU_SLT, 32'hFFFFFFFF,   32'd1,          5'd0, 32'd1,          1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1, ALU_SLL, 32'd0,          32'd3,          5'd4, 32'h00000030,   1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{0, ALU_BEQ, 32'd4,          32'd4,          5'd0, 32'd0,          1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{0, ALU_AND, 32'h0000000F,   32'h000000F0,   5'd0, 32'd0,          1'b1, 1'b0, 1'b1, 1'b0};

      bus.req_valid = 2'b11;
      bus.req_ctrl  = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_shamt = '0;
      bus.rsp_ready = 2'b00;

      // Reset state, with both requesters already asserting valid.
      tick();
      tick();
      check_all_zero("reset");
      bus.req_valid = 2'b00;
      rst = 1'b0;
      tick();

      // Single operations from the vector table.
      for (int i = 0; i < 10; i++) begin
         drive_req(vecs[i].port, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].shamt);
         #1;
         check("vec_req_ready", 32'(bus.req_ready), oh(vecs[i].port));
         tick();
         bus.req_valid = 2'b00;
         #1;
         check("vec_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check("vec_exec_alu_a", bus.alu_a, vecs[i].a);
         tick();
         check("vec_rsp_valid", 32'(bus.rsp_valid), oh(vecs[i].port));
         check("vec_rsp_result", bus.rsp_result, vecs[i].exp_res);
         check("vec_rsp_zero", 32'(bus.rsp_zero), 32'(vecs[i].exp_zero));
         check("vec_rsp_overflow", 32'(bus.rsp_overflow), 32'(vecs[i].exp_ovf));
         check("vec_rsp_we", 32'(bus.rsp_write_enable), 32'(vecs[i].exp_we));
         check("vec_rsp_jr", 32'(bus.rsp_jr_sel), 32'(vecs[i].exp_jr));
         $display("vec %0d: port %0d ctrl %0d a=%h b=%h -> result %h", i, vecs[i].port,
                  vecs[i].ctrl, vecs[i].a, vecs[i].b, bus.rsp_result);
         bus.rsp_ready[vecs[i].port] = 1'b1;
         tick();
         bus.rsp_ready = 2'b00;
         #1;
         check("vec_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end

      // Contention after reset: port 0 first, then strict alternation.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_req(0, ALU_SUB, 32'd9, 32'd9, 5'd0);
      drive_req(1, ALU_SUB, 32'd9, 32'd9, 5'd0);
      #1;
      check("cont_first_grant", 32'(bus.req_ready), 32'd1);
      exp_p = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("cont_exec_ready", 32'(bus.req_ready), 32'd0);
         tick();
         check("cont_rsp_valid", 32'(bus.rsp_valid), oh(exp_p));
         check("cont_rsp_result", bus.rsp_result, 32'd0);
         check("cont_rsp_zero", 32'(bus.rsp_zero), 32'd1);
         $display("contention %0d: response to port %0d result %h", k, exp_p, bus.rsp_result);
         bus.rsp_ready[exp_p] = 1'b1;
         #1;
         nxt_p = 1 - exp_p;
         check("cont_next_grant", 32'(bus.req_ready), oh(nxt_p));
         tick();
         bus.rsp_ready = 2'b00;
         exp_p = nxt_p;
      end
      bus.req_valid = 2'b00;
      tick();
      bus.rsp_ready[exp_p] = 1'b1;
      tick();
      bus.rsp_ready = 2'b00;

      // Backpressure on port 1 with port 0 waiting; port 0's ready is ignored.
      drive_req(1, ALU_ADD, 32'd1, 32'd2, 5'd0);
      #1;
      check("bp_grant1", 32'(bus.req_ready), 32'd2);
      tick();
      bus.req_valid = 2'b00;
      drive_req(0, ALU_ADD, 32'd4, 32'd4, 5'd0);
      #1;
      check("bp_exec_ready", 32'(bus.req_ready), 32'd0);
      tick();
      bus.rsp_ready = 2'b01;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_hold_valid", 32'(bus.rsp_valid), 32'd2);
         check("bp_hold_result", bus.rsp_result, 32'd3);
         check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
         $display("backpressure cycle %0d: rsp_valid %b result %h", c, bus.rsp_valid, bus.rsp_result);
         tick();
      end
      bus.rsp_ready = 2'b10;
      #1;
      check("bp_release_grant0", 32'(bus.req_ready), 32'd1);
      tick();
      bus.rsp_ready = 2'b00;
      bus.req_valid = 2'b00;
      tick();
      check("bp_rsp0_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp0_result", bus.rsp_result, 32'd8);
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;

      // Asynchronous reset while port 1's SLT is executing.
      drive_req(1, ALU_SLT, 32'd1, 32'd2, 5'd0);
      #1;
      check("rst_slt_grant", 32'(bus.req_ready), 32'd2);
      tick();
      bus.req_valid = 2'b00;
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid_exec");
      tick();
      tick();
      check("rst_rsp1_never", 32'(bus.rsp_valid), 32'd0);
      rst = 1'b0;
      drive_req(0, ALU_ADD, 32'd1, 32'd1, 5'd0);
      drive_req(1, ALU_ADD, 32'd1, 32'd1, 5'd0);
      #1;
      check("rst_first_grant", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 2'b00;
      tick();
      check("rst_after_valid", 32'(bus.rsp_valid), 32'd1);
      check("rst_after_result", bus.rsp_result, 32'd2);
      $display("post-reset op: rsp_valid %b result %h", bus.rsp_valid, bus.rsp_result);
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
